// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM states, the
// per-stage enable/flush bundle and the normal-flow decision helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t PIPE_CTRL_RUN = '{
        pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
        idex_flush: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1
    };

    // Unfrozen flow: a taken branch squashes IF/ID and ID/EX and wins over a
    // load-use bubble; a load-use holds PC and IF/ID for one cycle.
    function automatic pipe_ctrl_t run_rules(input logic br, input logic lu,
                                             input logic lu_prev);
        pipe_ctrl_t c;
        c = PIPE_CTRL_RUN;
        if (br) begin
            c.ifid_flush = 1'b1;
            c.idex_flush = 1'b1;
        end else if (lu && !lu_prev) begin
            c.pc_en      = 1'b0;
            c.ifid_en    = 1'b0;
            c.idex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: per-stage enables
// and bubbles from hazard, branch, dmem handshake and halt, plus perf counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64,
    parameter int TO_W        = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_hazard,
    input  logic             branch_taken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

    ctrl_state_t     state, state_nxt;
    logic [TO_W-1:0] wait_cnt, wait_nxt;
    logic            lu_prev, lu_fire, to_set;
    logic            freeze;
    pipe_ctrl_t      ctl, ctl_out;

    assign freeze = dmem_req && !dmem_ready;

    always_comb begin
        ctl       = '0;
        state_nxt = state;
        wait_nxt  = wait_cnt;
        lu_fire   = 1'b0;
        to_set    = 1'b0;
        case (state)
            RUN: begin
                if (halt_req) begin
                    state_nxt = HALTED;
                end else if (freeze) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = TO_W'(1);
                end else begin
                    ctl     = run_rules(branch_taken_ex, load_use_hazard, lu_prev);
                    lu_fire = !branch_taken_ex && load_use_hazard && !lu_prev;
                end
            end
            MEM_WAIT: begin
                // Branch/hazard inputs are held by the frozen EX/ID registers,
                // so they are only acted on in the cycle the access completes.
                if (dmem_ready) begin
                    ctl       = run_rules(branch_taken_ex, load_use_hazard, lu_prev);
                    lu_fire   = !branch_taken_ex && load_use_hazard && !lu_prev;
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == TO_LIM) begin
                    state_nxt = HALTED;
                    to_set    = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + TO_W'(1);
                end
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    // Reset must kill every enable immediately, not at the next edge.
    assign ctl_out = rst_n ? ctl : '0;

    assign pc_en      = ctl_out.pc_en;
    assign ifid_en    = ctl_out.ifid_en;
    assign ifid_flush = ctl_out.ifid_flush;
    assign idex_en    = ctl_out.idex_en;
    assign idex_flush = ctl_out.idex_flush;
    assign exmem_en   = ctl_out.exmem_en;
    assign memwb_en   = ctl_out.memwb_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            lu_prev     <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            lu_prev  <= lu_fire;
            if (to_set)
                mem_timeout <= 1'b1;
        end
    end

    assign halted = (state == HALTED);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!ctl_out.pc_en && (state != HALTED) && rst_n),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctl_out.ifid_flush),
        .count (flush_cnt)
    );

endmodule
